// File: rtl/cpu_pkg.sv
// Shared types and helpers for the decode-to-execute issue path.
package cpu_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic {
    RUN         = 1'b0,
    BRANCH_WAIT = 1'b1
  } issue_state_t;

  // One-hot select of an architectural register; x0 never maps to a bit.
  function automatic logic [REG_COUNT-1:0] one_hot_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic [REG_COUNT-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    mask[0]    = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Outstanding-write bitmap with three hazard queries that see same-cycle writebacks.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] set_addr,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] clear_addr,
  input  logic                      clear_en,
  input  logic [REG_ADDR_WIDTH-1:0] query_1_addr,
  input  logic                      query_1_en,
  input  logic [REG_ADDR_WIDTH-1:0] query_2_addr,
  input  logic                      query_2_en,
  input  logic [REG_ADDR_WIDTH-1:0] query_3_addr,
  input  logic                      query_3_en,
  output logic                      hazard
);

  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clear_mask;
  logic [REG_COUNT-1:0] effective;

  // NOTE: every combinational output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    set_mask   = set_en   ? one_hot_reg(set_addr)   : '0;
    clear_mask = clear_en ? one_hot_reg(clear_addr) : '0;
    effective  = pending & ~clear_mask;
    hazard     = (query_1_en & effective[query_1_addr])
               | (query_2_en & effective[query_2_addr])
               | (query_3_en & effective[query_3_addr]);
  end

  // Clear first, then set: a new write to a register retiring this cycle stays outstanding.
  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clear_mask) | set_mask;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Hazard-checking issue stage: holds one instruction for execute and serializes control flow.
module issue_scoreboard
  import cpu_pkg::*;
#(
  parameter int PAYLOAD_WIDTH     = 64,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         decode_valid,
  output logic                         decode_ready,
  input  logic [PAYLOAD_WIDTH-1:0]     decode_payload,
  input  logic [REG_ADDR_WIDTH-1:0]    register_1,
  input  logic                         register_1_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    register_2,
  input  logic                         register_2_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    write_register,
  input  logic                         write_register_valid,
  input  logic                         control_flow,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [PAYLOAD_WIDTH-1:0]     issue_payload,
  input  logic [REG_ADDR_WIDTH-1:0]    writeback_register,
  input  logic                         writeback_valid,
  input  logic                         resolve_valid,
  output logic [STALL_COUNT_WIDTH-1:0] stall_cycles
);

  issue_state_t state_q;
  issue_state_t state_d;
  logic         hazard;
  logic         accept;

  assign accept = decode_valid & decode_ready;

  reg_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_addr     (write_register),
    .set_en       (accept & write_register_valid),
    .clear_addr   (writeback_register),
    .clear_en     (writeback_valid),
    .query_1_addr (register_1),
    .query_1_en   (register_1_valid),
    .query_2_addr (register_2),
    .query_2_en   (register_2_valid),
    .query_3_addr (write_register),
    .query_3_en   (write_register_valid),
    .hazard       (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:         if (accept & control_flow) state_d = BRANCH_WAIT;
      BRANCH_WAIT: if (resolve_valid)         state_d = RUN;
      default:     state_d = RUN;
    endcase
  end

  // Ready is purely combinational so a writeback in this cycle can release a stalled instruction.
  always_comb begin
    decode_ready = !rst && (state_q == RUN) && !hazard && (!issue_valid || issue_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid   <= 1'b0;
      issue_payload <= '0;
    end else if (accept) begin
      issue_valid   <= 1'b1;
      issue_payload <= decode_payload;
    end else if (issue_ready) begin
      issue_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (decode_valid && !decode_ready && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed and randomized checks of issue_scoreboard against a register-set reference model.
module tb_issue_scoreboard;

  localparam int PW  = 64;
  localparam int SCW = 6;
  localparam int SAT = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           decode_valid;
  logic           decode_ready;
  logic [PW-1:0]  decode_payload;
  logic [4:0]     register_1, register_2, write_register, writeback_register;
  logic           register_1_valid, register_2_valid, write_register_valid;
  logic           control_flow;
  logic           issue_valid;
  logic           issue_ready;
  logic [PW-1:0]  issue_payload;
  logic           writeback_valid;
  logic           resolve_valid;
  logic [SCW-1:0] stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: set of outstanding destinations, branch-in-flight flag, issue slot, stall total.
  bit          pend_m[32];
  bit          branch_m;
  bit          slot_full_m;
  logic [PW-1:0] slot_m;
  int          stall_m;
  logic        last_ready;

  issue_scoreboard #(.PAYLOAD_WIDTH(PW), .STALL_COUNT_WIDTH(SCW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .decode_valid         (decode_valid),
    .decode_ready         (decode_ready),
    .decode_payload       (decode_payload),
    .register_1           (register_1),
    .register_1_valid     (register_1_valid),
    .register_2           (register_2),
    .register_2_valid     (register_2_valid),
    .write_register       (write_register),
    .write_register_valid (write_register_valid),
    .control_flow         (control_flow),
    .issue_valid          (issue_valid),
    .issue_ready          (issue_ready),
    .issue_payload        (issue_payload),
    .writeback_register   (writeback_register),
    .writeback_valid      (writeback_valid),
    .resolve_valid        (resolve_valid),
    .stall_cycles         (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A register blocks decode if still outstanding after this cycle's writeback retires.
  function automatic bit blocked(input logic [4:0] r);
    return (r != 5'd0) && pend_m[r] && !(writeback_valid && writeback_register == r);
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pend_m[i];
    return v;
  endfunction

  // One clock: ready checked mid-cycle, registered outputs checked 1 ns after the edge.
  task automatic step();
    bit exp_ready;
    bit acc;
    @(negedge clk);
    exp_ready = !rst && !branch_m && !(slot_full_m && !issue_ready)
              && !(register_1_valid && blocked(register_1))
              && !(register_2_valid && blocked(register_2))
              && !(write_register_valid && blocked(write_register));
    check("decode_ready", {63'd0, decode_ready}, {63'd0, exp_ready});
    last_ready = decode_ready;
    acc = decode_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
      branch_m    = 1'b0;
      slot_full_m = 1'b0;
      slot_m      = '0;
      stall_m     = 0;
    end else begin
      if (decode_valid && !exp_ready && stall_m < SAT) stall_m++;
      if (writeback_valid) pend_m[writeback_register] = 1'b0;
      if (acc && write_register_valid) pend_m[write_register] = 1'b1;
      pend_m[0] = 1'b0;
      if (branch_m && resolve_valid) branch_m = 1'b0;
      if (acc && control_flow) branch_m = 1'b1;
      if (acc) begin
        slot_full_m = 1'b1;
        slot_m      = decode_payload;
      end else if (issue_ready) begin
        slot_full_m = 1'b0;
      end
    end
    #1;
    check("issue_valid", {63'd0, issue_valid}, {63'd0, slot_full_m});
    check("issue_payload", issue_payload, slot_m);
    check("stall_cycles", {{(64-SCW){1'b0}}, stall_cycles}, 64'(stall_m));
    check("pending", {32'd0, dut.u_scoreboard.pending}, {32'd0, pend_vec()});
  endtask

  task automatic idle_inputs();
    decode_valid = 0; decode_payload = '0;
    register_1 = 0; register_1_valid = 0; register_2 = 0; register_2_valid = 0;
    write_register = 0; write_register_valid = 0; control_flow = 0;
    writeback_register = 0; writeback_valid = 0; resolve_valid = 0;
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    idle_inputs();
    rst = 1; issue_ready = 1;
    step(); step();
    rst = 0;
    check("reset_issue_valid", {63'd0, issue_valid}, 64'd0);
    check("reset_stall", {58'd0, stall_cycles}, 64'd0);

    // addi x15, x0, 23
    decode_valid = 1; decode_payload = 64'h0000_0000_0170_0793;
    register_1 = 0; register_1_valid = 1;
    write_register = 15; write_register_valid = 1;
    step();
    check("addi_ready", {63'd0, last_ready}, 64'd1);
    check("addi_issue_valid", {63'd0, issue_valid}, 64'd1);
    check("addi_payload", issue_payload, 64'h0000_0000_0170_0793);
    check("addi_pending15", {63'd0, dut.u_scoreboard.pending[15]}, 64'd1);
    check("addi_stall", {58'd0, stall_cycles}, 64'd0);

    // RAW on x15 for three cycles, then released by a same-cycle writeback
    decode_payload = 64'hAAAA_0000_0000_0001;
    register_1 = 15; register_1_valid = 1; write_register_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("raw_stall_ready", {63'd0, last_ready}, 64'd0);
    end
    check("raw_stall_count", {58'd0, stall_cycles}, 64'd3);
    writeback_register = 15; writeback_valid = 1;
    step();
    check("raw_wb_release", {63'd0, last_ready}, 64'd1);
    writeback_valid = 0; register_1_valid = 0;

    // Set/clear on x5 in the same cycle: the new write wins
    decode_payload = 64'h5;
    write_register = 5; write_register_valid = 1;
    step();
    writeback_register = 5; writeback_valid = 1;
    decode_payload = 64'h55;
    step();
    check("setclr_ready", {63'd0, last_ready}, 64'd1);
    check("setclr_pending5", {63'd0, dut.u_scoreboard.pending[5]}, 64'd1);

    // x0 destinations and sources never stall (first cycle also retires x5)
    write_register = 0; register_1 = 0; register_1_valid = 1; register_2 = 0; register_2_valid = 1;
    for (int i = 0; i < 4; i++) begin
      decode_payload = 64'(100 + i);
      step();
      writeback_valid = 0;
      check("x0_ready", {63'd0, last_ready}, 64'd1);
    end
    check("x0_pending", {32'd0, dut.u_scoreboard.pending}, 64'd0);
    register_1_valid = 0; register_2_valid = 0; write_register_valid = 0;

    // Backpressure then back-to-back issue
    decode_payload = 64'hA0A0_A0A0_A0A0_A0A0;
    step();
    issue_ready = 0; decode_payload = 64'hB0B0_B0B0_B0B0_B0B0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_ready", {63'd0, last_ready}, 64'd0);
      check("bp_payload_stable", issue_payload, 64'hA0A0_A0A0_A0A0_A0A0);
    end
    issue_ready = 1;
    step();
    check("b2b_valid", {63'd0, issue_valid}, 64'd1);
    check("b2b_payload", issue_payload, 64'hB0B0_B0B0_B0B0_B0B0);

    // Branch serialization and resolve
    control_flow = 1; decode_payload = 64'hB7;
    step();
    control_flow = 0; decode_payload = 64'hC0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("branch_wait_ready", {63'd0, last_ready}, 64'd0);
    end
    resolve_valid = 1;
    step();
    check("resolve_cycle_ready", {63'd0, last_ready}, 64'd0);
    resolve_valid = 0;
    step();
    check("after_resolve_ready", {63'd0, last_ready}, 64'd1);

    // Reset in the middle of a branch wait
    control_flow = 1; decode_payload = 64'hB8; write_register = 7; write_register_valid = 1;
    step();
    control_flow = 0; write_register_valid = 0;
    step();
    rst = 1; decode_valid = 0;
    step();
    rst = 0;
    check("rst_mid_valid", {63'd0, issue_valid}, 64'd0);
    check("rst_mid_pending", {32'd0, dut.u_scoreboard.pending}, 64'd0);
    check("rst_mid_stall", {58'd0, stall_cycles}, 64'd0);
    decode_valid = 1; decode_payload = 64'hD0;
    step();
    check("rst_mid_run", {63'd0, last_ready}, 64'd1);

    // Stall counter saturation while parked in branch wait
    control_flow = 1;
    step();
    control_flow = 0;
    for (int i = 0; i < SAT + 8; i++) step();
    check("stall_saturated", {58'd0, stall_cycles}, 64'(SAT));
    resolve_valid = 1;
    step();
    resolve_valid = 0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst                  = ($urandom_range(0, 149) == 0);
      decode_valid         = ($urandom_range(0, 3) != 0);
      decode_payload       = {$urandom, $urandom};
      register_1           = rand_reg();
      register_1_valid     = 1'($urandom_range(0, 1));
      register_2           = rand_reg();
      register_2_valid     = 1'($urandom_range(0, 1));
      write_register       = rand_reg();
      write_register_valid = ($urandom_range(0, 3) != 0);
      control_flow         = ($urandom_range(0, 7) == 0);
      issue_ready          = ($urandom_range(0, 3) != 0);
      writeback_register   = rand_reg();
      writeback_valid      = 1'($urandom_range(0, 1));
      resolve_valid        = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Sits between the instruction decoder and the execute stage.
- Accepts one decoded instruction per cycle and tracks outstanding register writes in a 32-entry scoreboard.
- Stalls on read-after-write and write-after-write hazards, and serializes control flow (branch/jump) until the branch is resolved.
- Presents a registered valid/ready issue port to execute and counts decode stall cycles for performance debug.

Parameters:
- PAYLOAD_WIDTH, 64, width of the opaque decoded-instruction bundle passed through to execute.
- STALL_COUNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- decode_valid  in  1  decoder presents a valid instruction (decoder opcode_valid).
- decode_ready  out  1  scoreboard accepts the instruction this cycle.
- decode_payload  in  PAYLOAD_WIDTH  decoded bundle (immediate, funct fields, etc.).
- register_1  in  5  source register 1.
- register_1_valid  in  1  rs1 is used.
- register_2  in  5  source register 2.
- register_2_valid  in  1  rs2 is used.
- write_register  in  5  destination register.
- write_register_valid  in  1  rd is written.
- control_flow  in  1  branch, immediate_jump or register_jump.
- issue_valid  out  1  issue register holds an instruction.
- issue_ready  in  1  execute accepts the instruction.
- issue_payload  out  PAYLOAD_WIDTH  registered copy of decode_payload.
- writeback_register  in  5  register completing writeback.
- writeback_valid  in  1  writeback occurs this cycle.
- resolve_valid  in  1  outstanding control-flow instruction resolved.
- stall_cycles  out  STALL_COUNT_WIDTH  saturating stall count.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pending all 0, state RUN, issue_valid 0, issue_payload 0, stall_cycles 0.
  - decode_ready is 0 while rst is high.
  - Reset mid-operation drops any held instruction and outstanding branch without handshake.
- Scoreboard:
  - pending[31:0]; bit 0 is hardwired 0, so x0 is never a hazard and is never set.
- Effective pending for the hazard check is `pending & ~wb_mask`, where wb_mask is the one-hot of writeback_register when writeback_valid=1. Same-cycle writeback therefore unblocks in that cycle.
- hazard = any of:
  - (register_1_valid & eff[register_1])
  - (register_2_valid & eff[register_2])
  - (write_register_valid & eff[write_register]), i.e. WAW.
- decode_ready = !rst & state==RUN & !hazard & (!issue_valid | issue_ready). It is combinational from the inputs; decode_valid must not depend on decode_ready.
- Accept = decode_valid & decode_ready:
  - Next cycle: issue_valid=1 and issue_payload=decode_payload.
  - If write_register_valid and write_register!=0, set that pending bit.
  - If control_flow=1, state moves to BRANCH_WAIT.
- Issue port:
  - issue_valid falls when issue_ready=1 and there is no accept in the same cycle.
  - Accept and issue in the same cycle gives back-to-back issue, one per cycle sustained.
  - issue_payload is stable while issue_valid=1 and issue_ready=0.
- Set/clear conflict on the same register in one cycle: set wins (the new write is outstanding).
- Writeback to a register that is not pending, or to x0: no effect.
- State machine:
  - RUN: normal operation.
  - BRANCH_WAIT: decode_ready=0; on resolve_valid go to RUN next cycle, so a new accept is possible the cycle after resolve.
  - resolve_valid in RUN is ignored.
  - Writebacks continue to clear bits in both states.
- stall_cycles increments by 1 on each cycle with decode_valid & !decode_ready & !rst, and saturates at all-ones.
- Latency: accept to issue_valid is 1 cycle.

Decomposition:
- Shared package (cpu_pkg):
  - REG_COUNT=32, REG_ADDR_WIDTH=5.
  - enum issue_state_t {RUN, BRANCH_WAIT}.
  - Function one_hot_reg(addr) returning a 32-bit mask with bit 0 forced to 0.
- One sub-module: reg_scoreboard.
  - Holds pending[31:0].
  - Inputs: set addr/en, clear addr/en, three query addr/en pairs.
  - Output: hazard.
- Issue register, FSM and stall counter stay in issue_scoreboard.

Test Plan:
- Reset, then accept addi x15,x0,23:
  - decode_ready=1.
  - Next cycle issue_valid=1, issue_payload matches, pending[15]=1.
  - stall_cycles=0.
- RAW: issue rd=x15, then present rs1=x15 with no writeback:
  - decode_ready=0 and stall_cycles counts 3 over 3 cycles.
  - writeback_valid with x15 → decode_ready=1 in that same cycle.
- Same-cycle set/clear: accept rd=x5 while writeback_register=x5 is valid → pending[5]=1 afterwards.
- x0: stream of rd=x0 then rs1=x0 → never stalls, pending stays 0.
- Backpressure: hold issue_ready=0 for 4 cycles → issue_payload stable, decode_ready=0. Then issue_ready=1 with a new decode_valid → back-to-back issue with no bubble.
- Branch:
  - Accept with control_flow=1 → decode_ready=0 until resolve_valid.
  - Accept is possible the cycle after resolve.
  - Assert rst mid-BRANCH_WAIT → state RUN, issue_valid=0, pending=0, stall_cycles=0.
